// File: rtl/trace_record_v12_decoder.sv
// Trace record deserializer: rebuilds v1.1 (6-word) / v1.2 (8-word) records from a 64-bit stream,
// checks framing and reports decoded fields with queueing overhead. Optional: SEQ_CHECK_EN.
module trace_record_v12_decoder #(
  parameter int CNT_W      = 16,
  parameter bit ACCEPT_V11 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [7:0]       rec_version,
  output logic [7:0]       rec_type,
  output logic [15:0]      rec_core_id,
  output logic [31:0]      rec_seq_no,
  output logic [15:0]      rec_tx_id,
  output logic [15:0]      rec_flags,
  output logic [63:0]      rec_t_ingress,
  output logic [63:0]      rec_t_egress,
  output logic [63:0]      rec_t_host,
  output logic             rec_has_attr,
  output logic [127:0]     rec_deltas,
  output logic [63:0]      rec_overhead,
  output logic             rec_attr_err,
  output logic [CNT_W-1:0] err_version_cnt,
  output logic [CNT_W-1:0] err_frame_cnt,
  output logic [CNT_W-1:0] seq_gap_cnt
);

  typedef enum logic [1:0] {ST_HDR, ST_BODY, ST_OUT, ST_DROP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_live;
  logic [2:0]       r_idx, r_last_idx;
  logic [7:0]       r_version, r_type;
  logic [15:0]      r_core_id, r_tx_id, r_flags;
  logic [31:0]      r_seq_no, r_d_ingress, r_d_core;
  logic [63:0]      r_t_ingress, r_t_egress, r_t_host, r_overhead;
  logic [127:0]     r_deltas;
  logic             r_has_attr, r_attr_err;
  logic [CNT_W-1:0] r_err_version_cnt, r_err_frame_cnt;

  logic             w_accept, w_hdr_ok, w_is_last, w_ver_err, w_frame_err, w_rec_done;
  logic [63:0]      w_total, w_overhead;
  logic [33:0]      w_sum;
  logic             w_neg, w_sum_over, w_attr_err;

  // r_live holds s_tready low while in reset and on the first edge after release.
  assign s_tready    = r_live && (r_state != ST_OUT);
  assign w_accept    = s_tvalid && s_tready;
  assign w_hdr_ok    = (s_tdata[63:56] == 8'h02) || ((s_tdata[63:56] == 8'h01) && ACCEPT_V11);
  assign w_is_last   = (r_idx == r_last_idx);
  assign w_ver_err   = w_accept && (r_state == ST_HDR) && !w_hdr_ok;
  assign w_frame_err = w_accept && (((r_state == ST_BODY) && (w_is_last != s_tlast)) ||
                                    ((r_state == ST_HDR) && w_hdr_ok && s_tlast));
  assign w_rec_done  = w_accept && (r_state == ST_BODY) && w_is_last && s_tlast;

  // Last-word arithmetic: d_risk/d_egress come straight off the bus in the final v1.2 word.
  assign w_total    = r_t_egress - r_t_ingress;
  assign w_sum      = 34'(r_d_ingress) + 34'(r_d_core) + 34'(s_tdata[63:32]) + 34'(s_tdata[31:0]);
  assign w_neg      = r_t_egress < r_t_ingress;
  assign w_sum_over = 64'(w_sum) > w_total;
  assign w_attr_err = w_neg || (r_has_attr && w_sum_over);
  assign w_overhead = w_attr_err ? '0 : (r_has_attr ? (w_total - 64'(w_sum)) : w_total);

  always_comb begin
    // NOTE: assigning the default before the case means every path drives the signal, so no latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_HDR: if (w_accept) begin
        if (!w_hdr_ok)     w_state_nxt = s_tlast ? ST_HDR : ST_DROP;
        else if (!s_tlast) w_state_nxt = ST_BODY;
      end
      ST_BODY: if (w_accept) begin
        if (w_is_last)    w_state_nxt = s_tlast ? ST_OUT : ST_DROP;
        else if (s_tlast) w_state_nxt = ST_HDR;
      end
      ST_OUT:  if (rec_ready) w_state_nxt = ST_HDR;
      ST_DROP: if (w_accept && s_tlast) w_state_nxt = ST_HDR;
      default: w_state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HDR;
      r_live  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_last_idx  <= '0;
      r_version   <= '0;
      r_type      <= '0;
      r_core_id   <= '0;
      r_seq_no    <= '0;
      r_tx_id     <= '0;
      r_flags     <= '0;
      r_t_ingress <= '0;
      r_t_egress  <= '0;
      r_t_host    <= '0;
      r_d_ingress <= '0;
      r_d_core    <= '0;
      r_has_attr  <= 1'b0;
      r_deltas    <= '0;
      r_overhead  <= '0;
      r_attr_err  <= 1'b0;
    end else begin
      if (w_accept && (r_state == ST_HDR) && w_hdr_ok) begin
        r_version  <= s_tdata[63:56];
        r_type     <= s_tdata[55:48];
        r_core_id  <= s_tdata[47:32];
        r_seq_no   <= s_tdata[31:0];
        r_has_attr <= (s_tdata[63:56] == 8'h02);
        r_last_idx <= (s_tdata[63:56] == 8'h02) ? 3'd7 : 3'd5;
        r_idx      <= 3'd1;
      end
      if (w_accept && (r_state == ST_BODY)) begin
        r_idx <= r_idx + 3'd1;
        case (r_idx)
          3'd1:    r_t_ingress <= s_tdata;
          3'd2:    r_t_egress  <= s_tdata;
          3'd3:    r_t_host    <= s_tdata;
          3'd4:    {r_tx_id, r_flags} <= s_tdata[63:32];
          3'd6:    {r_d_ingress, r_d_core} <= s_tdata;
          default: ;
        endcase
      end
      if (w_rec_done) begin
        r_deltas   <= r_has_attr ? {r_d_ingress, r_d_core, s_tdata} : '0;
        r_overhead <= w_overhead;
        r_attr_err <= w_attr_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_version_cnt <= '0;
      r_err_frame_cnt   <= '0;
    end else begin
      if (w_ver_err && (r_err_version_cnt != '1)) r_err_version_cnt <= r_err_version_cnt + CNT_W'(1);
      if (w_frame_err && (r_err_frame_cnt != '1)) r_err_frame_cnt   <= r_err_frame_cnt + CNT_W'(1);
    end
  end

`ifdef SEQ_CHECK_EN
  logic             r_seq_seeded;
  logic [31:0]      r_seq_last;
  logic [CNT_W-1:0] r_seq_gap_cnt;

  // Only completed records advance the tracker; REC_RESET (type 0x03) re-seeds without counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_seeded  <= 1'b0;
      r_seq_last    <= '0;
      r_seq_gap_cnt <= '0;
    end else if (w_rec_done) begin
      r_seq_seeded <= 1'b1;
      r_seq_last   <= r_seq_no;
      if (r_seq_seeded && (r_type != 8'h03) && (r_seq_no != r_seq_last + 32'd1) &&
          (r_seq_gap_cnt != '1))
        r_seq_gap_cnt <= r_seq_gap_cnt + CNT_W'(1);
    end
  end
  assign seq_gap_cnt = r_seq_gap_cnt;
`else
  assign seq_gap_cnt = '0;
`endif

  assign rec_valid       = (r_state == ST_OUT);
  assign rec_version     = r_version;
  assign rec_type        = r_type;
  assign rec_core_id     = r_core_id;
  assign rec_seq_no      = r_seq_no;
  assign rec_tx_id       = r_tx_id;
  assign rec_flags       = r_flags;
  assign rec_t_ingress   = r_t_ingress;
  assign rec_t_egress    = r_t_egress;
  assign rec_t_host      = r_t_host;
  assign rec_has_attr    = r_has_attr;
  assign rec_deltas      = r_deltas;
  assign rec_overhead    = r_overhead;
  assign rec_attr_err    = r_attr_err;
  assign err_version_cnt = r_err_version_cnt;
  assign err_frame_cnt   = r_err_frame_cnt;

endmodule

// File: tb/tb_trace_record_v12_decoder.sv
// Scoreboard bench for trace_record_v12_decoder: expected records queued at send time,
// popped and compared on each rec_valid&rec_ready handshake.
module tb_trace_record_v12_decoder;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [63:0]      s_tdata;
  logic             s_tvalid, s_tready, s_tlast;
  logic             rec_valid, rec_ready;
  logic [7:0]       rec_version, rec_type;
  logic [15:0]      rec_core_id, rec_tx_id, rec_flags;
  logic [31:0]      rec_seq_no;
  logic [63:0]      rec_t_ingress, rec_t_egress, rec_t_host, rec_overhead;
  logic             rec_has_attr, rec_attr_err;
  logic [127:0]     rec_deltas;
  logic [CNT_W-1:0] err_version_cnt, err_frame_cnt, seq_gap_cnt;

  trace_record_v12_decoder #(.CNT_W(CNT_W), .ACCEPT_V11(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_version(rec_version), .rec_type(rec_type), .rec_core_id(rec_core_id),
    .rec_seq_no(rec_seq_no), .rec_tx_id(rec_tx_id), .rec_flags(rec_flags),
    .rec_t_ingress(rec_t_ingress), .rec_t_egress(rec_t_egress), .rec_t_host(rec_t_host),
    .rec_has_attr(rec_has_attr), .rec_deltas(rec_deltas), .rec_overhead(rec_overhead),
    .rec_attr_err(rec_attr_err), .err_version_cnt(err_version_cnt),
    .err_frame_cnt(err_frame_cnt), .seq_gap_cnt(seq_gap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ver, typ;
    logic [15:0] core;
    logic [31:0] seq;
    logic [15:0] tx, flags;
    logic [63:0] ti, te, th;
    logic [31:0] d0, d1, d2, d3;
  } rec_t;

  typedef struct packed {
    rec_t         r;
    logic         has_attr;
    logic [127:0] deltas;
    logic [63:0]  ovh;
    logic         aerr;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_err = 0;
  int          exp_ver_cnt = 0, exp_frame_cnt = 0, exp_gap = 0;
  bit          seq_seeded = 0;
  logic [31:0] seq_last = '0;
  bit          chk_rdy = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", tag);
  endtask

  function automatic rec_t mk(input logic [7:0] ver, input logic [7:0] typ, input logic [31:0] seq,
                              input logic [63:0] ti, input logic [63:0] te,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3);
    rec_t r;
    r.ver = ver; r.typ = typ; r.core = 16'h1234 + seq[15:0]; r.seq = seq;
    r.tx = seq[15:0] ^ 16'hbeef; r.flags = 16'h0005;
    r.ti = ti; r.te = te; r.th = te + 64'd5;
    r.d0 = d0; r.d1 = d1; r.d2 = d2; r.d3 = d3;
    return r;
  endfunction

  // Reference decode straight from the record description.
  function automatic exp_t model(input rec_t r);
    exp_t        e;
    logic [63:0] total, sum;
    e.r        = r;
    e.has_attr = (r.ver == 8'h02);
    total      = r.te - r.ti;
    sum        = 64'(r.d0) + 64'(r.d1) + 64'(r.d2) + 64'(r.d3);
    if (e.has_attr) begin
      e.deltas = {r.d0, r.d1, r.d2, r.d3};
      e.aerr   = (r.te < r.ti) || (sum > total);
      e.ovh    = e.aerr ? 64'd0 : total - sum;
    end else begin
      e.deltas = '0;
      e.aerr   = (r.te < r.ti);
      e.ovh    = e.aerr ? 64'd0 : total;
    end
    return e;
  endfunction

  function automatic logic [63:0] word_of(input rec_t r, input int i);
    case (i)
      0:       return {r.ver, r.typ, r.core, r.seq};
      1:       return r.ti;
      2:       return r.te;
      3:       return r.th;
      4:       return {r.tx, r.flags, 32'h0};
      5:       return 64'hdead_beef_0000_0005;
      6:       return {r.d0, r.d1};
      default: return {r.d2, r.d3};
    endcase
  endfunction

  task automatic push_expected(input rec_t r);
    q.push_back(model(r));
`ifdef SEQ_CHECK_EN
    if (seq_seeded && r.typ != 8'h03 && r.seq != seq_last + 32'd1) exp_gap++;
`endif
    seq_seeded = 1;
    seq_last   = r.seq;
  endtask

  task automatic drive_word(input logic [63:0] d, input bit last);
    bit done = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (s_tready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) timeout_fail("s_tready_wait");
  endtask

  task automatic send(input rec_t r, input int nwords, input int last_at, input bit good);
    if (good) push_expected(r);
    for (int i = 0; i < nwords; i++) drive_word(word_of(r, i), i == last_at);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) timeout_fail("rec_output_wait");
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_rdy) begin
        check("hdr_ready_after_out", s_tready, 1'b1);
        chk_rdy = 0;
      end
      if (rec_valid && rec_ready) begin
        if (q.size() == 0) begin
          check("spurious_rec_valid", rec_valid, 1'b0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("version",   rec_version,   e.r.ver);
          check("type",      rec_type,      e.r.typ);
          check("core_id",   rec_core_id,   e.r.core);
          check("seq_no",    rec_seq_no,    e.r.seq);
          check("tx_id",     rec_tx_id,     e.r.tx);
          check("flags",     rec_flags,     e.r.flags);
          check("t_ingress", rec_t_ingress, e.r.ti);
          check("t_egress",  rec_t_egress,  e.r.te);
          check("t_host",    rec_t_host,    e.r.th);
          check("has_attr",  rec_has_attr,  e.has_attr);
          check("deltas",    rec_deltas,    e.deltas);
          check("overhead",  rec_overhead,  e.ovh);
          check("attr_err",  rec_attr_err,  e.aerr);
        end
        chk_rdy = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    bit   seen;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; rec_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready",  s_tready,        1'b0);
    check("rst_rec_valid", rec_valid,       1'b0);
    check("rst_ver_cnt",   err_version_cnt, 0);
    check("rst_frame_cnt", err_frame_cnt,   0);
    check("rst_gap_cnt",   seq_gap_cnt,     0);
    check("rst_overhead",  rec_overhead,    0);
    @(posedge clk); #1 rst_n = 1'b1;

    // v1.2 nominal: overhead 150-110 = 40; v1.1 nominal: overhead 7, no deltas.
    send(mk(8'h02, 8'h01, 32'd7, 64'd100, 64'd250, 32'd10, 32'd50, 32'd20, 32'd30), 8, 7, 1);
    wait_drained();
    send(mk(8'h01, 8'h01, 32'd8, 64'd0, 64'd7, 32'd1, 32'd1, 32'd1, 32'd1), 6, 5, 1);
    wait_drained();

    // Bad version with full body, then a good record (seq 10 is a gap after 8).
    send(mk(8'h05, 8'h01, 32'd9, 64'd1, 64'd2, 0, 0, 0, 0), 8, 7, 0);
    exp_ver_cnt++;
    check("ver_cnt_after_v5", err_version_cnt, exp_ver_cnt);
    send(mk(8'h02, 8'h01, 32'd10, 64'd1000, 64'd2000, 32'd1, 32'd2, 32'd3, 32'd4), 8, 7, 1);
    wait_drained();
    check("gap_after_7_8_10", seq_gap_cnt, exp_gap);
    send(mk(8'h02, 8'h03, 32'd0, 64'd5, 64'd9, 0, 0, 0, 0), 8, 7, 1);
    send(mk(8'h02, 8'h01, 32'd1, 64'd5, 64'd90, 32'd5, 0, 0, 32'd5), 8, 7, 1);
    wait_drained();
    check("gap_after_rec_reset", seq_gap_cnt, exp_gap);

    // Early tlast on w4, then attribution underflow (sum 400 > total 50).
    send(mk(8'h02, 8'h01, 32'd2, 64'd1, 64'd2, 0, 0, 0, 0), 5, 4, 0);
    exp_frame_cnt++;
    check("frame_cnt_early", err_frame_cnt, exp_frame_cnt);
    send(mk(8'h02, 8'h01, 32'd2, 64'd300, 64'd350, 32'd100, 32'd100, 32'd100, 32'd100), 8, 7, 1);
    wait_drained();

    // Missing tlast on v1.1 w5 (arrives on w6), and a lone bad header carrying tlast.
    send(mk(8'h01, 8'h01, 32'd99, 64'd1, 64'd2, 0, 0, 0, 0), 7, 6, 0);
    exp_frame_cnt++;
    check("frame_cnt_late", err_frame_cnt, exp_frame_cnt);
    send(mk(8'hff, 8'h01, 32'd98, 64'd1, 64'd2, 0, 0, 0, 0), 1, 0, 0);
    exp_ver_cnt++;
    check("ver_cnt_hdr_tlast", err_version_cnt, exp_ver_cnt);

    // Consumer stall: output held, input blocked.
    rec_ready = 1'b0;
    send(mk(8'h02, 8'h01, 32'd3, 64'd40, 64'd900, 32'd7, 32'd8, 32'd9, 32'd10), 8, 7, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rec_valid;
    end
    if (!seen) timeout_fail("stall_rec_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_s_tready", s_tready,     1'b0);
      check("stall_valid",    rec_valid,    1'b1);
      check("stall_seq",      rec_seq_no,   q[0].r.seq);
      check("stall_overhead", rec_overhead, q[0].ovh);
    end
    @(posedge clk); #1 rec_ready = 1'b1;
    wait_drained();

    for (int k = 0; k < 6; k++) begin
      logic [63:0] ti;
      logic [7:0]  ver;
      ver = (k % 2 == 1) ? 8'h01 : 8'h02;
      ti  = 64'($urandom);
      r   = mk(ver, 8'h01, 32'(4 + k), ti, ti + 64'($urandom_range(0, 2000)),
               32'($urandom_range(0, 600)), 32'($urandom_range(0, 600)),
               32'($urandom_range(0, 600)), 32'($urandom_range(0, 600)));
      send(r, (ver == 8'h02) ? 8 : 6, (ver == 8'h02) ? 7 : 5, 1);
      wait_drained();
    end
    send(mk(8'h01, 8'h01, 32'd10, 64'd500, 64'd400, 0, 0, 0, 0), 6, 5, 1);
    wait_drained();

    // Reset in the middle of a record (after w2), then a fresh record.
    r = mk(8'h02, 8'h01, 32'd50, 64'd11, 64'd22, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_word(word_of(r, i), 1'b0);
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    check("midrst_s_tready",  s_tready,        1'b0);
    check("midrst_valid",     rec_valid,       1'b0);
    check("midrst_version",   rec_version,     0);
    check("midrst_t_ingress", rec_t_ingress,   0);
    check("midrst_overhead",  rec_overhead,    0);
    check("midrst_ver_cnt",   err_version_cnt, 0);
    check("midrst_frame_cnt", err_frame_cnt,   0);
    check("midrst_gap_cnt",   seq_gap_cnt,     0);
    exp_ver_cnt = 0; exp_frame_cnt = 0; exp_gap = 0; seq_seeded = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    send(mk(8'h02, 8'h02, 32'd100, 64'd1000, 64'd1100, 32'd10, 32'd10, 32'd10, 32'd10), 8, 7, 1);
    wait_drained();
    check("end_ver_cnt",   err_version_cnt, exp_ver_cnt);
    check("end_frame_cnt", err_frame_cnt,   exp_frame_cnt);
    check("end_gap_cnt",   seq_gap_cnt,     exp_gap);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
